uart_fifo_param: RTL

- Parametrised fabric-register FIFO for the UART 16550 data path; one instance per direction (Rx and Tx).
- Supersedes fixed 512x9 hard-FIFO wrapping with fabric storage of configurable width and depth.
- Adds capabilities absent before: a programmable trigger-level flag, sticky overflow/underflow errors, and a 16550 non-FIFO (depth-1 holding register) mode selected at run time.

---
 rtl/uart_fifo_param.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_fifo_param.sv
// -----------------------------------------------------------------------------
// uart_fifo_param
//
// Fabric-register FIFO for the UART 16550 data path. One instance is used per
// direction (Rx and Tx). Entries are DATA_WIDTH bits wide and the FIFO holds
// DEPTH = 2**ADDR_WIDTH entries in FIFO mode, or a single entry in 16550
// holding-register (non-FIFO) mode. The head entry is presented show-ahead.
//
// Ports
//   WBs_CLK_i      in   fabric clock, all logic on the rising edge
//   WBs_RSTn_i     in   synchronous active-low reset
//   FIFO_Enable_i  in   1 = FIFO mode (capacity DEPTH), 0 = holding register
//   Flush_i        in   synchronous flush of pointers and level
//   Push_i         in   write strobe, one entry per cycle
//   Push_DAT_i     in   write data
//   Pop_i          in   read strobe, one entry per cycle
//   Pop_DAT_o      out  head entry (show-ahead), zero while empty
//   Trig_Level_i   in   trigger threshold, 0 disables the trigger
//   Clr_Err_i      in   clears the sticky error flags
//   Level_o        out  current occupancy, 0..DEPTH
//   Empty_o        out  Level_o == 0
//   Full_o         out  Level_o == capacity
//   Trig_o         out  occupancy has reached Trig_Level_i
//   Overflow_o     out  sticky: a push was dropped
//   Underflow_o    out  sticky: a pop was ignored
// -----------------------------------------------------------------------------
module uart_fifo_param #(
    parameter int DATA_WIDTH = 11,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  WBs_CLK_i,
    input  logic                  WBs_RSTn_i,
    input  logic                  FIFO_Enable_i,
    input  logic                  Flush_i,
    input  logic                  Push_i,
    input  logic [DATA_WIDTH-1:0] Push_DAT_i,
    input  logic                  Pop_i,
    output logic [DATA_WIDTH-1:0] Pop_DAT_o,
    input  logic [ADDR_WIDTH:0]   Trig_Level_i,
    input  logic                  Clr_Err_i,
    output logic [ADDR_WIDTH:0]   Level_o,
    output logic                  Empty_o,
    output logic                  Full_o,
    output logic                  Trig_o,
    output logic                  Overflow_o,
    output logic                  Underflow_o
);

    localparam int                DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_LVL   = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   level_q;
    logic [ADDR_WIDTH:0]   level_d;
    logic [ADDR_WIDTH:0]   capacity;
    logic                  mode_q;
    logic                  flush;
    logic                  is_empty;
    logic                  is_full;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  ovf_set;
    logic                  udf_set;

    // Accept decisions and next occupancy.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        capacity = FIFO_Enable_i ? DEPTH_LVL : ONE_LVL;
        // Any change of FIFO_Enable_i against its registered copy flushes the
        // FIFO on the edge that first samples the new mode (16550 FCR rule).
        flush    = Flush_i | (FIFO_Enable_i != mode_q);
        is_empty = (level_q == '0);
        is_full  = (level_q == capacity);

        // A full FIFO still accepts a push when a pop frees the slot the same cycle.
        pop_ok   = !flush && Pop_i && !is_empty;
        push_ok  = !flush && Push_i && (!is_full || Pop_i);
        ovf_set  = !flush && Push_i && !Pop_i && is_full;
        udf_set  = !flush && Pop_i && is_empty;

        level_d  = level_q;
        if (flush) begin
            level_d = '0;
        end else if (push_ok && !pop_ok) begin
            level_d = level_q + ONE_LVL;
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - ONE_LVL;
        end
    end

    // Pointers, registered flags and sticky errors.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge WBs_CLK_i) begin
        if (!WBs_RSTn_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            Empty_o     <= 1'b1;
            Full_o      <= 1'b0;
            Trig_o      <= 1'b0;
            Overflow_o  <= 1'b0;
            Underflow_o <= 1'b0;
            // Track the live mode so leaving reset never causes a spurious flush.
            mode_q      <= FIFO_Enable_i;
        end else begin
            mode_q <= FIFO_Enable_i;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            end

            level_q <= level_d;
            Empty_o <= (level_d == '0);
            Full_o  <= (level_d == capacity);
            // Re-evaluated every cycle so a threshold change lands one cycle later.
            Trig_o  <= (Trig_Level_i != '0) && (level_d >= Trig_Level_i);

            // Set wins over clear when both happen in the same cycle.
            if (ovf_set)        Overflow_o  <= 1'b1;
            else if (Clr_Err_i) Overflow_o  <= 1'b0;
            if (udf_set)        Underflow_o <= 1'b1;
            else if (Clr_Err_i) Underflow_o <= 1'b0;
        end
    end

    // Storage array.
    // NOTE: the array has no reset; stale contents are unreachable because the
    // read data is masked while empty, and a reset-free array maps to plain flops.
    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RSTn_i && push_ok) begin
            mem[wr_ptr] <= Push_DAT_i;
        end
    end

    assign Level_o   = level_q;
    assign Pop_DAT_o = Empty_o ? '0 : mem[rd_ptr];

endmodule
